word_merger: RTL and testbench

- Inverse of the field splitter: packs a stream of narrow chunks into one full-width word.
- Upstream side is a valid/ready chunk port with an end-of-word marker. Downstream side is a valid/ready word port with a chunk count.
- Sits between byte-serial sources (UART/loader style) and 32-bit datapath consumers such as registers and memory write ports.

---
 rtl/word_merger.sv | 92 +++++++++
 tb/tb_word_merger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_merger.sv
// word_merger: packs a stream of CHUNK_W-bit chunks into CHUNKS-chunk words.
//
// Ports:
//   clk        system clock, rising-edge
//   reset      asynchronous active-low reset
//   in_valid   chunk present on in_data/in_last
//   in_ready   merger can accept a chunk (= !out_valid | out_ready)
//   in_data    chunk payload
//   in_last    chunk ends the current word (partial words allowed)
//   out_valid  out_data/out_len hold a completed word
//   out_ready  consumer takes the word this cycle
//   out_data   assembled word, unfilled slots zero
//   out_len    number of valid chunks in out_data, 1..CHUNKS
//
// Build option: WORD_MERGER_BIG_ENDIAN_EN places the first chunk in the MSBs
// instead of the LSBs. Handshake and timing are identical in both builds.
module word_merger #(
    parameter int unsigned CHUNK_W = 8,
    parameter int unsigned CHUNKS  = 4,
    parameter int unsigned LEN_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK_W-1:0]        in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHUNK_W*CHUNKS-1:0] out_data,
    output logic [LEN_W-1:0]          out_len
);

    localparam int unsigned WORD_W = CHUNK_W * CHUNKS;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(CHUNKS - 1);

    logic [LEN_W-1:0]  count;
    logic [WORD_W-1:0] buffer;
    logic [WORD_W-1:0] merged;
    logic [LEN_W-1:0]  slot;
    logic              accept;
    logic              deliver;
    logic              complete;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;
    assign complete = accept && ((count == LAST_IDX) || in_last);

`ifdef WORD_MERGER_BIG_ENDIAN_EN
    assign slot = LAST_IDX - count;
`else
    assign slot = count;
`endif

    // Buffer with the incoming chunk dropped into its slot.
    always_comb begin
        merged = buffer;
        for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (slot == LEN_W'(k)) begin
                merged[k*CHUNK_W +: CHUNK_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            buffer    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (complete) begin
            // A completing accept also covers a same-cycle deliver: the new
            // word replaces the old one with no bubble.
            out_data  <= merged;
            out_len   <= count + 1'b1;
            out_valid <= 1'b1;
            count     <= '0;
            buffer    <= '0;
        end else begin
            if (accept) begin
                buffer <= merged;
                count  <= count + 1'b1;
            end
            if (deliver) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_merger.sv
module tb_word_merger;

    localparam int unsigned CHUNK_W = 8;
    localparam int unsigned CHUNKS  = 4;
    localparam int unsigned LEN_W   = 3;

`ifdef WORD_MERGER_BIG_ENDIAN_EN
    localparam logic [31:0] W_FULL  = 32'h11223344;
    localparam logic [31:0] W_PART  = 32'hAABB0000;
    localparam logic [31:0] W_SEQ   = 32'h01020304;
    localparam logic [31:0] W_STALL = 32'h99770000;
    localparam logic [31:0] W_B0    = 32'h00010203;
    localparam logic [31:0] W_B1    = 32'h04050607;
    localparam logic [31:0] W_B2    = 32'h08090A0B;
`else
    localparam logic [31:0] W_FULL  = 32'h44332211;
    localparam logic [31:0] W_PART  = 32'h0000BBAA;
    localparam logic [31:0] W_SEQ   = 32'h04030201;
    localparam logic [31:0] W_STALL = 32'h00007799;
    localparam logic [31:0] W_B0    = 32'h03020100;
    localparam logic [31:0] W_B1    = 32'h07060504;
    localparam logic [31:0] W_B2    = 32'h0B0A0908;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_len;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    word_merger #(.CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: chunks collected in a queue, a word is formed by
    // shifting each chunk to its byte position once the word is closed.
    logic [7:0]  m_q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_len = '0;
    logic        m_in_ready;
    assign m_in_ready = !m_valid || out_ready;

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] w = '0;
        int unsigned pos;
        for (int k = 0; k < q.size(); k++) begin
`ifdef WORD_MERGER_BIG_ENDIAN_EN
            pos = CHUNKS - 1 - k;
`else
            pos = k;
`endif
            w = w | (32'(q[k]) << (8 * pos));
        end
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_valid = 1'b0;
                m_data  = '0;
                m_len   = '0;
            end else begin
                logic acc, del, done;
                acc  = in_valid && m_in_ready;
                del  = m_valid && out_ready;
                done = 1'b0;
                if (acc) begin
                    m_q.push_back(in_data);
                    if (m_q.size() == CHUNKS || in_last) begin
                        m_data  = pack(m_q);
                        m_len   = 3'(m_q.size());
                        m_valid = 1'b1;
                        m_q.delete();
                        done = 1'b1;
                    end
                end
                if (del && !done) m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready",  64'(in_ready),  64'(m_in_ready));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_data",  64'(out_data),  64'(m_data));
            check("out_len",   64'(out_len),   64'(m_len));
        end
    end

    // Words delivered to the consumer.
    logic [31:0] got[$];
    initial begin
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) got.push_back(out_data);
        end
    end

    // Presents one chunk and returns #1 after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        check("send_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    // Word must appear at the negedge right after the completing accept.
    task automatic expect_word(input string name, input logic [31:0] w, input logic [2:0] len);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"},  64'(out_data),  64'(w));
        check({name, "_len"},   64'(out_len),   64'(len));
    endtask

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_len",   64'(out_len),   64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Full word, out_valid for exactly one cycle.
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        expect_word("full", W_FULL, 3'd4);
        @(negedge clk);
        check("full_drop", 64'(out_valid), 64'd0);
        check("full_hold", 64'(out_data), 64'(W_FULL));
        @(posedge clk); #1;

        // Partial word then a full one.
        send(8'hAA, 0); send(8'hBB, 1);
        expect_word("part", W_PART, 3'd2);
        @(posedge clk); #1;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        expect_word("seq", W_SEQ, 3'd4);
        @(posedge clk); #1;

        // Backpressure with a chunk waiting on the input.
        out_ready = 1'b0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        in_valid = 1'b1; in_data = 8'h99; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", 64'(out_data), 64'(W_FULL));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drop", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send(8'h77, 1);
        expect_word("stall", W_STALL, 3'd2);
        @(posedge clk); #1;

        // Back-to-back burst relying on count wrap.
        got.delete();
        t0 = cyc;
        for (int i = 0; i < 12; i++) send(8'(i), 0);
        check("b2b_cycles", 64'(cyc - t0), 64'd12);
        repeat (2) @(negedge clk);
        check("b2b_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            check("b2b_w0", 64'(got[0]), 64'(W_B0));
            check("b2b_w1", 64'(got[1]), 64'(W_B1));
            check("b2b_w2", 64'(got[2]), 64'(W_B2));
        end
        @(posedge clk); #1;

        // Reset with a pending word.
        out_ready = 1'b0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        @(negedge clk);
        check("pend_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("pend_rst_valid", 64'(out_valid), 64'd0);
        check("pend_rst_data",  64'(out_data),  64'd0);
        check("pend_rst_len",   64'(out_len),   64'd0);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-word.
        send(8'h55, 0); send(8'h66, 0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        expect_word("after_rst", W_SEQ, 3'd4);
        @(posedge clk); #1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
